// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: handshaked calc unit sitting between decode and writeback.
//
// Base ops (opt 0-7) and the null ops (E/F) return a registered result one
// cycle after accept. With ALU_MULDIV_EN defined, opt 8-D run an iterative
// shift-add multiplier (XLEN+1 cycles) or a restoring divider plus a sign
// fix-up cycle (XLEN+2 cycles). Without ALU_MULDIV_EN, opt 8-D return 0
// after one cycle and no iteration state exists.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   request handshake; opt, a, b captured on accept
//   out_valid / out_ready result handshake; result held while stalled
//   result                XLEN-bit result
//   busy                  multi-cycle op in progress (MUL, DIV or FIX)
module alu_seq_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      opt,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int SHAMT_W = $clog2(XLEN);

  function automatic logic [XLEN-1:0] base_op(input logic [2:0] op,
                                              input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y);
    logic signed [XLEN-1:0] xs;
    logic [SHAMT_W-1:0]     sh;
    logic [XLEN-1:0]        r;
    xs = x;
    sh = y[SHAMT_W-1:0];
    r  = '0;
    case (op)
      3'd0:    r = x + y;
      3'd1:    r = x - y;
      3'd2:    r = x << sh;
      3'd3:    r = xs >>> sh;
      3'd4:    r = x >> sh;
      3'd5:    r = x & y;
      3'd6:    r = x | y;
      default: r = x ^ y;
    endcase
    return r;
  endfunction

  logic            accept;
  logic            single;
  logic [XLEN-1:0] single_res;
  logic            produce;
  logic [XLEN-1:0] res_nxt;
  logic            multi_done;
  logic [XLEN-1:0] multi_res;

  assign accept = in_valid && in_ready;

`ifdef ALU_MULDIV_EN

  // Two's-complement magnitude; -2^(XLEN-1) maps onto itself, which the
  // unsigned divider treats as 2^(XLEN-1).
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic sgn);
    logic signed [XLEN-1:0] sv;
    sv = v;
    return (sgn && sv < 0) ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v,
                                                 input logic neg);
    return neg ? -v : v;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  state_t state, state_nxt;

  logic [SHAMT_W-1:0] cnt;
  logic [XLEN-1:0]    opa;     // multiplicand or divisor magnitude
  logic [XLEN-1:0]    hi;      // product high half / partial remainder
  logic [XLEN-1:0]    lo;      // multiplier -> product low half / quotient
  logic               hi_sel;  // MULHU or remainder result
  logic               neg_q;
  logic               neg_r;
  logic               last;

  logic               is_mul, is_div, sgn_op;
  logic               start_mul, start_div;

  logic [XLEN:0]      mul_sum;
  logic [XLEN-1:0]    mul_hi_nxt, mul_lo_nxt;
  logic [XLEN:0]      div_shift, div_trial;
  logic [XLEN-1:0]    div_hi_nxt, div_lo_nxt;

  assign is_mul    = (opt == 4'h8) || (opt == 4'h9);
  assign is_div    = (opt >= 4'hA) && (opt <= 4'hD);
  assign sgn_op    = opt[2];
  assign start_mul = accept && is_mul;
  assign start_div = accept && is_div && (b != '0);
  assign single    = accept && !start_mul && !start_div;
  assign last      = (cnt == '0);

  // Shift-add step: add multiplicand on multiplier LSB, shift the 2*XLEN
  // product (with carry) right by one.
  assign mul_sum    = {1'b0, hi} + (lo[0] ? {1'b0, opa} : '0);
  assign mul_hi_nxt = mul_sum[XLEN:1];
  assign mul_lo_nxt = {mul_sum[0], lo[XLEN-1:1]};

  // Restoring step: bring in the next dividend bit and keep the
  // subtraction only if it does not go negative.
  assign div_shift  = {hi, lo[XLEN-1]};
  assign div_trial  = div_shift - {1'b0, opa};
  assign div_hi_nxt = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
  assign div_lo_nxt = {lo[XLEN-2:0], ~div_trial[XLEN]};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_mul)      state_nxt = S_MUL;
        else if (start_div) state_nxt = S_DIV;
      end
      S_MUL:   if (last) state_nxt = S_IDLE;
      S_DIV:   if (last) state_nxt = S_FIX;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      opa    <= '0;
      hi     <= '0;
      lo     <= '0;
      hi_sel <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_mul) begin
            cnt    <= SHAMT_W'(XLEN - 1);
            opa    <= a;
            hi     <= '0;
            lo     <= b;
            hi_sel <= opt[0];
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
          end else if (start_div) begin
            cnt    <= SHAMT_W'(XLEN - 1);
            opa    <= magnitude(b, sgn_op);
            hi     <= '0;
            lo     <= magnitude(a, sgn_op);
            hi_sel <= opt[0];
            neg_q  <= sgn_op && (a[XLEN-1] ^ b[XLEN-1]);
            neg_r  <= sgn_op && a[XLEN-1];
          end
        end
        S_MUL: begin
          hi  <= mul_hi_nxt;
          lo  <= mul_lo_nxt;
          cnt <= cnt - 1'b1;
        end
        S_DIV: begin
          hi  <= div_hi_nxt;
          lo  <= div_lo_nxt;
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    multi_done = 1'b0;
    multi_res  = '0;
    if (state == S_MUL && last) begin
      multi_done = 1'b1;
      multi_res  = hi_sel ? mul_hi_nxt : mul_lo_nxt;
    end else if (state == S_FIX) begin
      multi_done = 1'b1;
      multi_res  = hi_sel ? apply_sign(hi, neg_r) : apply_sign(lo, neg_q);
    end
  end

`else

  assign single     = accept;
  assign multi_done = 1'b0;
  assign multi_res  = '0;
  assign busy       = 1'b0;
  assign in_ready   = !out_valid || out_ready;

`endif

  always_comb begin
    single_res = '0;
    if (!opt[3]) single_res = base_op(opt[2:0], a, b);
`ifdef ALU_MULDIV_EN
    // Only divide-by-zero reaches here among A-D: quotient all ones,
    // remainder returns the dividend.
    else if (is_div) single_res = opt[0] ? a : '1;
`endif
  end

  always_comb begin
    produce = single || multi_done;
    res_nxt = single ? single_res : multi_res;
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (produce) begin
      out_valid <= 1'b1;
      result    <= res_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
module tb_alu_seq_muldiv;

  localparam int XLEN = 32;
`ifdef ALU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      opt;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq_muldiv #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opt       (opt),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] xa;
    logic [31:0] xb;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] exp, input int lat, input string name);
    vec_t v;
    v.op = op; v.xa = xa; v.xb = xb; v.exp = exp; v.lat = lat; v.name = name;
    // Without the muldiv option, opcodes 8-D collapse to a 1-cycle zero.
    if (!MD_EN && op >= 4'h8 && op <= 4'hD) begin
      v.exp = 32'h0;
      v.lat = 1;
    end
    vq.push_back(v);
  endtask

  // Issue one op, scramble the inputs right after accept, wait for result.
  task automatic do_op(input logic [3:0] op, input logic [31:0] xa, input logic [31:0] xb,
                       output logic [31:0] res, output int lat, output logic bad_busy);
    @(negedge clk);
    opt = op; a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; opt = ~op; a = ~xa; b = xb ^ 32'h5A5A_5A5A;
    lat = 1;
    bad_busy = 1'b0;
    while (!out_valid && lat < 100) begin
      if (!busy || in_ready) bad_busy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    logic        bad_busy;
    logic [31:0] hold_exp;
    logic        seen;
    logic [3:0]  bb_op [3];
    logic [31:0] bb_a  [3];
    logic [31:0] bb_b  [3];
    logic [31:0] bb_e  [3];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opt = 4'h0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset result", result, 32'h0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    add_vec(4'h0, 32'hFFFF_FFFF, 32'h1,         32'h0000_0000, 1,  "add wrap");
    add_vec(4'h1, 32'h5,         32'h7,         32'hFFFF_FFFE, 1,  "sub neg");
    add_vec(4'h2, 32'h1,         32'h24,        32'h0000_0010, 1,  "sll shamt");
    add_vec(4'h3, 32'h8000_0000, 32'h21,        32'hC000_0000, 1,  "sra");
    add_vec(4'h4, 32'h8000_0000, 32'h21,        32'h4000_0000, 1,  "srl");
    add_vec(4'h5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1,  "and");
    add_vec(4'h6, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1,  "or");
    add_vec(4'h7, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1,  "xor");
    add_vec(4'hE, 32'h1,         32'h2,         32'h0,         1,  "op E");
    add_vec(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1,  "op F");
    add_vec(4'h8, 32'h1234_5678, 32'h10,        32'h2345_6780, 33, "mul");
    add_vec(4'h9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    add_vec(4'h8, 32'hFFFF_FFFF, 32'h3,         32'hFFFF_FFFD, 33, "mul neg");
    add_vec(4'hC, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 34, "div -7/2");
    add_vec(4'hD, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 34, "rem -7/2");
    add_vec(4'hC, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "div ovf");
    add_vec(4'hD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         34, "rem ovf");
    add_vec(4'hC, 32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div 7/-2");
    add_vec(4'hD, 32'h7,         32'hFFFF_FFFE, 32'h1,         34, "rem 7/-2");
    add_vec(4'hA, 32'd100,       32'd7,         32'd14,        34, "divu");
    add_vec(4'hB, 32'd100,       32'd7,         32'd2,         34, "remu");
    add_vec(4'hA, 32'hFFFF_FFFF, 32'h2,         32'h7FFF_FFFF, 34, "divu big");
    add_vec(4'hA, 32'h1234,      32'h0,         32'hFFFF_FFFF, 1,  "divu by0");
    add_vec(4'hB, 32'h5,         32'h0,         32'h5,         1,  "remu by0");
    add_vec(4'hC, 32'h5,         32'h0,         32'hFFFF_FFFF, 1,  "div by0");
    add_vec(4'hD, 32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, 1,  "rem by0");

    foreach (vq[i]) begin
      do_op(vq[i].op, vq[i].xa, vq[i].xb, res, lat, bad_busy);
      chk({vq[i].name, " result"}, res, vq[i].exp);
      chk({vq[i].name, " latency"}, lat, vq[i].lat);
      chk({vq[i].name, " busy/in_ready"}, {31'b0, bad_busy}, 32'd0);
    end

    // Back-to-back single-cycle ops.
    bb_op[0] = 4'h0; bb_a[0] = 32'd10; bb_b[0] = 32'd20;         bb_e[0] = 32'd30;
    bb_op[1] = 4'h1; bb_a[1] = 32'd10; bb_b[1] = 32'd3;          bb_e[1] = 32'd7;
    bb_op[2] = 4'h7; bb_a[2] = 32'hFF; bb_b[2] = 32'h0F;         bb_e[2] = 32'hF0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      opt = bb_op[i]; a = bb_a[i]; b = bb_b[i]; in_valid = 1'b1; out_ready = 1'b1;
      chk("b2b in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      chk("b2b out_valid", {31'b0, out_valid}, 32'd1);
      chk("b2b result", result, bb_e[i]);
    end
    in_valid = 1'b0;

    // Output hold under back-pressure.
    hold_exp = MD_EN ? 32'h5 : 32'h0;
    @(negedge clk);
    opt = 4'hB; a = 32'h5; b = 32'h0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; opt = 4'h0; a = 32'h1; b = 32'h1;
    chk("hold first", result, hold_exp);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("hold out_valid", {31'b0, out_valid}, 32'd1);
      chk("hold result", result, hold_exp);
      chk("hold in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("release out_valid", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    opt = 4'h8; a = 32'h1234_5678; b = 32'h10; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid-mul busy", {31'b0, busy}, {31'b0, MD_EN});
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort in_ready", {31'b0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort no stale result", {31'b0, seen}, 32'd0);
    do_op(4'h0, 32'd2, 32'd3, res, lat, bad_busy);
    chk("post-abort add", res, 32'd5);
    chk("post-abort latency", lat, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_muldiv.md
Name: alu_seq_muldiv

Overview:
- Parametrised, handshaked successor to the CPU's single-cycle calc functions.
- Executes the base calc ops (add/sub/shifts/logic) with one-cycle registered latency.
- Adds iterative multiply, divide and remainder (unsigned and signed) over an XLEN-cycle datapath.
- Sits between decode and writeback; the core stalls on in_ready / out_valid.

Parameters:
- XLEN, 32, operand/result width; must be a power of two and at least 8.
- SHAMT_W, $clog2(XLEN) (localparam, not overridable), shift-amount width taken from b.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request this cycle
- opt  in  4  opcode
- a  in  XLEN  operand a
- b  in  XLEN  operand b
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  result value
- busy  out  1  multi-cycle op in progress (state MUL, DIV or FIX)

Behaviour:
- Reset: in_ready=1, out_valid=0, result=0, busy=0, state=IDLE, all iteration registers cleared.
- Reset mid-operation aborts the operation and discards any pending result.
- Accept occurs when in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready), which allows back-to-back single-cycle ops.
- Output hold: while out_valid && !out_ready, result and out_valid stay stable.
- Output release: out_valid falls on the cycle after out_ready, unless a new result is produced in that same cycle.
- Opcodes 0-7, same as existing calc:
  - 0 a+b; 1 a-b; 2 a<<b[SHAMT_W-1:0]; 3 arithmetic a>>>shamt; 4 logical a>>shamt; 5 and; 6 or; 7 xor.
  - All wrap modulo 2^XLEN; out_valid rises the cycle after accept.
- Opcodes 8-D:
  - 8 MUL: low XLEN bits of a*b.
  - 9 MULHU: high XLEN bits of the unsigned product.
  - A DIVU, B REMU: unsigned divide / remainder.
  - C DIV, D REM: signed, quotient truncated toward zero, remainder takes the sign of the dividend.
- Opcodes E, F: result 0, one-cycle latency.
- FSM:
  - IDLE -> MUL on accept of 8/9.
  - IDLE -> DIV on accept of A-D with b!=0.
  - MUL: shift-add one bit per cycle, XLEN cycles, then -> IDLE with out_valid=1. Latency accept-to-out_valid = XLEN+1 cycles.
  - DIV: restoring, one quotient bit per cycle on operand magnitudes, XLEN cycles, then -> FIX.
  - FIX: applies sign correction (signed ops only; unsigned ops pass through unchanged), then -> IDLE with out_valid=1. Latency XLEN+2 cycles for all divides.
- Divide by zero (b==0), no iteration, one-cycle latency:
  - Quotient = all ones.
  - Remainder = a.
- Signed overflow (a = -2^(XLEN-1), b = -1) goes through normal DIV/FIX timing:
  - Quotient = a.
  - Remainder = 0.
- Inputs are captured at accept; later changes to a, b or opt do not affect an in-flight operation.
- in_valid while busy is ignored (in_ready=0).

Optional Feature:
- Macro ALU_MULDIV_EN.
- Defined: opcodes 8-D behave as above; MUL/DIV/FIX states and iteration registers are instantiated.
- Undefined:
  - Opcodes 8-D behave like E/F: result 0, one-cycle latency.
  - busy is tied to 0; FSM reduces to IDLE only; no multiplier/divider registers are synthesised.

Test Plan (XLEN=32):
- opt=0, a=0xFFFFFFFF, b=1 -> result 0x00000000, out_valid 1 cycle after accept; opt=3, a=0x80000000, b=0x21 -> result 0xC0000000 (shamt=1).
- Back-to-back: add, sub, xor accepted on 3 consecutive cycles with out_ready=1 -> 3 results on 3 consecutive cycles, in_ready constant 1.
- opt=8, a=0x12345678, b=0x10 -> 0x23456780 at cycle 33; opt=9, a=b=0xFFFFFFFF -> 0xFFFFFFFE; busy=1 and in_ready=0 throughout.
- opt=C, a=-7, b=2 -> 0xFFFFFFFD (-3) at cycle 34; opt=D, same operands -> 0xFFFFFFFF (-1); opt=C, a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
- opt=A, b=0 -> 0xFFFFFFFF at cycle 1; opt=B, a=5, b=0 -> 5; out_ready held 0 for 4 cycles -> result stable, in_ready=0.
- Assert rst at cycle 10 of a MUL -> next cycle out_valid=0, busy=0, in_ready=1; a following add (opt=0, a=2, b=3) returns 5.
